// File: rtl/vga_pkg.sv
// Shared VGA raster constants and capture FSM encoding, used by the capture
// block and by any timing generator that drives it.
package vga_pkg;

    localparam int VGA_H_TOTAL     = 800;
    localparam int VGA_H_ACT_START = 144;
    localparam int VGA_H_ACT_END   = 783;
    localparam int VGA_V_TOTAL     = 525;
    localparam int VGA_V_ACT_START = 35;
    localparam int VGA_V_ACT_END   = 514;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } vga_state_e;

endpackage

// File: rtl/vga_sync_edge.sv
// Registers one sync pin and flags its rising edge from the registered value
// and the value one clock earlier.
module vga_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sync,
    output logic o_rise
);

    logic r_sync_p0;
    logic r_sync_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_p0 <= 1'b0;
            r_sync_p1 <= 1'b0;
        end else begin
            r_sync_p0 <= i_sync;
            r_sync_p1 <= r_sync_p0;
        end
    end

    assign o_rise = r_sync_p0 & ~r_sync_p1;

endmodule

// File: rtl/vga_capture.sv
// VGA capture: measures incoming raster timing, locks after one verified frame
// and emits active pixels with coordinates, two clocks after the pins.
module vga_capture
    import vga_pkg::*;
#(
    parameter int H_TOTAL     = VGA_H_TOTAL,
    parameter int H_ACT_START = VGA_H_ACT_START,
    parameter int H_ACT_END   = VGA_H_ACT_END,
    parameter int V_TOTAL     = VGA_V_TOTAL,
    parameter int V_ACT_START = VGA_V_ACT_START,
    parameter int V_ACT_END   = VGA_V_ACT_END
) (
    input  logic       clk_25M,
    input  logic       rst_n,
    input  logic       Hsync,
    input  logic       Vsync,
    input  logic [2:0] vgaRed,
    input  logic [2:0] vgaGreen,
    input  logic [1:0] vgaBlue,
    output logic       pix_valid,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic [7:0] pix_data,
    output logic       frame_start,
    output logic       locked,
    output logic       sync_err,
    output logic [9:0] line_len
);

    localparam logic [9:0] LP_H_TOTAL     = 10'(H_TOTAL);
    localparam logic [9:0] LP_H_ACT_START = 10'(H_ACT_START);
    localparam logic [9:0] LP_H_ACT_END   = 10'(H_ACT_END);
    localparam logic [9:0] LP_V_TOTAL     = 10'(V_TOTAL);
    localparam logic [9:0] LP_V_ACT_START = 10'(V_ACT_START);
    localparam logic [9:0] LP_V_ACT_END   = 10'(V_ACT_END);

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    logic       w_hrise;
    logic       w_vrise;
    logic [7:0] r_rgb_p0;
    logic [9:0] r_hcnt;
    logic [9:0] w_hcnt;
    logic [9:0] w_line_len;
    logic [9:0] r_vcnt;
    logic [9:0] w_vinc;
    vga_state_e r_state;
    logic       r_bad;
    logic       w_len_err;
    logic       w_hto_err;
    logic       w_vlen_err;
    logic       w_vto_err;
    logic       w_err;
    logic       w_active;

    // Input stage: sync pins via the edge detectors, colour alongside them.
    vga_sync_edge u_hsync (
        .clk    (clk_25M),
        .rst_n  (rst_n),
        .i_sync (Hsync),
        .o_rise (w_hrise)
    );

    vga_sync_edge u_vsync (
        .clk    (clk_25M),
        .rst_n  (rst_n),
        .i_sync (Vsync),
        .o_rise (w_vrise)
    );

    always_ff @(posedge clk_25M or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb_p0 <= 8'd0;
        end else begin
            r_rgb_p0 <= {vgaRed, vgaGreen, vgaBlue};
        end
    end

    // h_cnt is 0 in the rise cycle itself so it stays aligned with r_rgb_p0.
    assign w_hcnt     = w_hrise ? 10'd0 : sat_inc(r_hcnt);
    assign w_line_len = sat_inc(r_hcnt);
    assign w_vinc     = sat_inc(r_vcnt);

    assign w_len_err  = w_hrise && (w_line_len != LP_H_TOTAL);
    assign w_hto_err  = (w_hcnt == LP_H_TOTAL);
    assign w_vlen_err = w_vrise && (w_vinc != LP_V_TOTAL);
    assign w_vto_err  = w_hrise && !w_vrise && (w_vinc == LP_V_TOTAL);
    assign w_err      = w_len_err || w_hto_err || w_vlen_err || w_vto_err;

    always_ff @(posedge clk_25M or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt   <= 10'd0;
            r_vcnt   <= 10'd0;
            line_len <= 10'd0;
        end else begin
            r_hcnt <= w_hcnt;
            if (w_hrise) begin
                r_vcnt   <= w_vrise ? 10'd0 : w_vinc;
                line_len <= w_line_len;
            end
        end
    end

    // Errors take priority over a coincident Vsync rise in LOCKED.
    always_ff @(posedge clk_25M or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_SEARCH;
            r_bad       <= 1'b0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            sync_err    <= 1'b0;
            frame_start <= w_vrise;
            case (r_state)
                ST_SEARCH: begin
                    if (w_vrise) begin
                        r_state <= ST_MEASURE;
                        r_bad   <= 1'b0;
                    end
                end
                ST_MEASURE: begin
                    if (w_vrise) begin
                        if (r_bad || w_err) begin
                            r_state <= ST_SEARCH;
                        end else begin
                            r_state <= ST_LOCKED;
                            locked  <= 1'b1;
                        end
                    end else if (w_err) begin
                        r_bad <= 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (w_err) begin
                        r_state  <= ST_SEARCH;
                        locked   <= 1'b0;
                        sync_err <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_SEARCH;
                    locked  <= 1'b0;
                end
            endcase
        end
    end

    assign w_active = locked
                   && (w_hcnt >= LP_H_ACT_START) && (w_hcnt <= LP_H_ACT_END)
                   && (r_vcnt >= LP_V_ACT_START) && (r_vcnt <= LP_V_ACT_END);

    // Output stage: coordinates and colour hold while outside the active area.
    always_ff @(posedge clk_25M or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid <= 1'b0;
            pix_x     <= 10'd0;
            pix_y     <= 10'd0;
            pix_data  <= 8'd0;
        end else begin
            pix_valid <= w_active;
            if (w_active) begin
                pix_x    <= w_hcnt - LP_H_ACT_START;
                pix_y    <= r_vcnt - LP_V_ACT_START;
                pix_data <= r_rgb_p0;
            end
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a reduced raster (160x12, 128x8 active)
// so that many frames fit in a short run; colour on each pixel equals pix_x.
module tb_vga_capture;

    localparam int HT       = 160;
    localparam int HA0      = 24;
    localparam int HA1      = 151;
    localparam int VT       = 12;
    localparam int VA0      = 3;
    localparam int VA1      = 10;
    localparam int HS_W     = 12;
    localparam int VS_LINES = 2;
    localparam int NONE     = -1;
    localparam int ALL      = 1000;

    logic       clk_25M  = 1'b0;
    logic       rst_n    = 1'b1;
    logic       Hsync    = 1'b0;
    logic       Vsync    = 1'b0;
    logic [2:0] vgaRed   = 3'd0;
    logic [2:0] vgaGreen = 3'd0;
    logic [1:0] vgaBlue  = 2'd0;
    logic       pix_valid;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic [7:0] pix_data;
    logic       frame_start;
    logic       locked;
    logic       sync_err;
    logic [9:0] line_len;

    int n_chk    = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int n_badpix = 0;
    int n_err    = 0;
    int n_fs     = 0;
    logic [7:0] cap_first = 8'hEE;
    logic [7:0] cap_last  = 8'hEE;
    int v0, e0, f0;

    always #20 clk_25M = ~clk_25M;

    vga_capture #(
        .H_TOTAL     (HT),
        .H_ACT_START (HA0),
        .H_ACT_END   (HA1),
        .V_TOTAL     (VT),
        .V_ACT_START (VA0),
        .V_ACT_END   (VA1)
    ) dut (
        .clk_25M     (clk_25M),
        .rst_n       (rst_n),
        .Hsync       (Hsync),
        .Vsync       (Vsync),
        .vgaRed      (vgaRed),
        .vgaGreen    (vgaGreen),
        .vgaBlue     (vgaBlue),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_data    (pix_data),
        .frame_start (frame_start),
        .locked      (locked),
        .sync_err    (sync_err),
        .line_len    (line_len)
    );

    // Event counters sampled just after each rising edge.
    always @(posedge clk_25M) begin
        #1;
        if (pix_valid) begin
            n_valid++;
            if (pix_data !== pix_x[7:0]) n_badpix++;
            if (pix_x == 10'd0 && pix_y == 10'd0) cap_first = pix_data;
            if (pix_x == 10'(HA1 - HA0) && pix_y == 10'(VA1 - VA0)) cap_last = pix_data;
        end
        if (sync_err) n_err++;
        if (frame_start) n_fs++;
    end

    initial begin
        #(40 * 80000);
        $display("FAIL watchdog: run did not finish, checks=%0d", n_chk);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic hs, input logic vs, input logic [7:0] rgb);
        @(negedge clk_25M);
        Hsync = hs;
        Vsync = vs;
        {vgaRed, vgaGreen, vgaBlue} = rgb;
    endtask

    task automatic send_line(input int len, input bit hs_en, input bit vs);
        for (int h = 0; h < len; h++) drive(hs_en && (h < HS_W), vs, 8'(h - HA0));
    endtask

    task automatic send_lines(input int first, input int last, input int short_line,
                              input int hs_off_from);
        for (int l = first; l <= last; l++)
            send_line((l == short_line) ? HT - 1 : HT, l < hs_off_from, l < VS_LINES);
    endtask

    initial begin
        // Reset state
        #1 rst_n = 1'b0;
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 8'h00);
        check("rst_locked", locked, 0);
        check("rst_valid", pix_valid, 0);
        check("rst_sync_err", sync_err, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_line_len", line_len, 0);
        check("rst_pix", {pix_x, pix_y, pix_data}, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 8'h00);

        // Nominal: lock at second Vsync rise, full frame of pixels
        f0 = n_fs;
        e0 = n_err;
        send_lines(0, VT - 1, NONE, ALL);
        check("f1_not_locked", locked, 0);
        v0 = n_valid;
        send_lines(0, 0, NONE, ALL);
        check("f2_locked", locked, 1);
        send_lines(1, VT - 1, NONE, ALL);
        check("f2_valid_count", n_valid - v0, 1024);
        check("f2_bad_pixels", n_badpix, 0);
        check("f2_pix00_data", cap_first, 8'h00);
        check("f2_pixlast_data", cap_last, 8'h7F);
        check("f2_line_len", line_len, HT);
        check("f2_no_sync_err", n_err - e0, 0);
        check("f2_frame_starts", n_fs - f0, 2);

        // Pixel-accurate latency on row 2 (line 5)
        send_lines(0, 4, NONE, ALL);
        for (int h = 0; h < HT; h++) begin
            drive(h < HS_W, 1'b0, 8'(h - HA0));
            if (h == HA0 + 1) begin
                check("lat_not_yet_valid", pix_valid, 0);
                check("lat_hold_data", pix_data, 8'h7F);
            end
            if (h == HA0 + 2) begin
                check("lat_valid", pix_valid, 1);
                check("lat_pix_x", pix_x, 0);
                check("lat_pix_y", pix_y, 2);
                check("lat_pix_data", pix_data, 8'h00);
            end
            if (h == HA0 + 3) check("lat_next_pix", {pix_x, pix_data}, {10'd1, 8'h01});
        end
        send_lines(6, VT - 1, NONE, ALL);

        // Short line while locked
        e0 = n_err;
        send_lines(0, 6, 5, ALL);
        check("short_err_once", n_err - e0, 1);
        check("short_unlocked", locked, 0);
        check("short_line_len", line_len, HT - 1);
        send_lines(7, VT - 1, NONE, ALL);
        send_lines(0, VT - 1, NONE, ALL);
        send_lines(0, VT - 1, NONE, ALL);
        check("short_relocked", locked, 1);
        check("short_err_total", n_err - e0, 1);

        // Hsync removed while locked
        send_lines(0, 3, NONE, ALL);
        e0 = n_err;
        for (int h = 0; h < HT; h++) begin
            drive(1'b0, 1'b0, 8'(h - HA0));
            if (h == 1) check("hto_before", {locked, sync_err}, 2'b10);
            if (h == 2) check("hto_sync_err", sync_err, 1);
            if (h == 3) begin
                check("hto_pulse_end", sync_err, 0);
                check("hto_unlocked", locked, 0);
                v0 = n_valid;
            end
        end
        send_lines(5, VT - 1, NONE, 0);
        check("hto_no_valid", n_valid - v0, 0);
        check("hto_err_once", n_err - e0, 1);

        // Short frame (one line missing) during MEASURE
        e0 = n_err;
        send_lines(0, VT - 2, NONE, ALL);
        check("vshort_measure_unlocked", locked, 0);
        send_lines(0, VT - 1, NONE, ALL);
        check("vshort_after_g1", locked, 0);
        check("vshort_no_sync_err", n_err - e0, 0);
        send_lines(0, VT - 1, NONE, ALL);
        check("vshort_after_g2", locked, 0);
        send_lines(0, VT - 1, NONE, ALL);
        check("vshort_relocked", locked, 1);
        check("vshort_err_total", n_err - e0, 0);

        // Reset pulse mid-line while locked
        send_lines(0, 4, NONE, ALL);
        for (int h = 0; h < HT; h++) begin
            drive(h < HS_W, 1'b0, 8'(h - HA0));
            if (h == 59) begin
                check("mrst_pre_locked", locked, 1);
                check("mrst_pre_valid", pix_valid, 1);
                #5 rst_n = 1'b0;
                #1;
                check("mrst_locked", locked, 0);
                check("mrst_valid", pix_valid, 0);
                check("mrst_pix", {pix_x, pix_y, pix_data}, 0);
                check("mrst_line_len", line_len, 0);
            end
            if (h == 63) rst_n = 1'b1;
        end
        f0 = n_fs;
        send_lines(6, VT - 1, NONE, ALL);
        check("mrst_no_fs_midframe", n_fs - f0, 0);
        send_lines(0, VT - 1, NONE, ALL);
        check("mrst_fs_next_vrise", n_fs - f0, 1);
        check("mrst_not_locked_yet", locked, 0);
        send_lines(0, VT - 1, NONE, ALL);
        check("mrst_locked_again", locked, 1);

        $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- H_TOTAL, 800, pixel clocks per line.
- H_ACT_START, 144, first active h count.
- H_ACT_END, 783, last active h count.
- V_TOTAL, 525, lines per frame.
- V_ACT_START, 35, first active line.
- V_ACT_END, 514, last active line.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning. One clock; reset is asynchronous and active-low.
- clk_25M  in  1  pixel clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Hsync  in  1  active-high line sync.
- Vsync  in  1  active-high frame sync.
- vgaRed  in  3  red sample.
- vgaGreen  in  3  green sample.
- vgaBlue  in  2  blue sample.
- pix_valid  out  1  pix_* hold an active pixel.
- pix_x  out  10  column, 0..639.
- pix_y  out  10  row, 0..479.
- pix_data  out  8  {R,G,B} as RGB332.
- frame_start  out  1  one-cycle pulse at Vsync rise.
- locked  out  1  timing verified.
- sync_err  out  1  one-cycle pulse on timing violation.
- line_len  out  10  last measured line length, saturating at 1023.

Function
REQ-003 Input stage SHALL register Hsync, Vsync and the 8 colour bits on every clock; all detection SHALL use registered values.
REQ-004 Hsync rise SHALL be detected as registered Hsync = 1 while the previous registered value = 0; Vsync rise SHALL be detected the same way.
REQ-005 h_cnt SHALL be 0 in the Hsync-rise cycle and SHALL increment by 1 otherwise, saturating at 1023.
REQ-006 At each Hsync rise, v_cnt SHALL be cleared to 0 if a Vsync rise occurs in the same cycle; otherwise it SHALL increment by 1, saturating at 1023.
REQ-007 At each Hsync rise, line_len SHALL load the previous h_cnt+1, saturating at 1023.
REQ-008 FSM states SHALL be SEARCH, MEASURE and LOCKED.
- SEARCH to MEASURE on a Vsync rise.
- MEASURE to LOCKED on the next Vsync rise, if every line in the frame measured H_TOTAL and the frame had V_TOTAL lines.
- Otherwise MEASURE SHALL go to SEARCH.
REQ-009 In LOCKED, sync_err SHALL pulse and the FSM SHALL return to SEARCH on any of:
- a measured line length other than H_TOTAL;
- h_cnt reaching H_TOTAL without an Hsync rise;
- a Vsync rise with v_cnt+1 other than V_TOTAL;
- v_cnt reaching V_TOTAL without a Vsync rise.
REQ-010 Exit from MEASURE on failure SHALL NOT pulse sync_err.
REQ-011 locked SHALL be 1 only in LOCKED.
REQ-012 pix_valid SHALL be 1 iff locked, H_ACT_START<=h_cnt<=H_ACT_END and V_ACT_START<=v_cnt<=V_ACT_END.
REQ-013 When pix_valid = 1: pix_x SHALL be h_cnt-H_ACT_START, pix_y SHALL be v_cnt-V_ACT_START, and pix_data SHALL be the registered colour sample of that h_cnt.
REQ-014 When pix_valid = 0, pix_x, pix_y and pix_data SHALL hold their last values.
REQ-015 Latency from input pins to pix_* outputs SHALL be 2 clocks (input register plus output register).
REQ-016 frame_start SHALL pulse in the cycle after any Vsync rise, in every FSM state.
REQ-017 Simultaneous error and Vsync rise SHALL resolve as error first: the FSM goes to SEARCH and does not take SEARCH to MEASURE in that cycle.

Reset
REQ-018 While rst_n = 0, all registers and outputs SHALL be 0, with the FSM in SEARCH.
REQ-019 Reset assertion mid-frame SHALL take effect immediately, without waiting for a clock edge.
REQ-020 After reset release, lock SHALL require a full SEARCH, MEASURE, LOCKED sequence.

Structure
REQ-021 Timing constants and the FSM state encoding SHALL live in the shared package vga_pkg, used by both vga_capture and the timing generator.
REQ-022 The edge-detect input register SHALL be one sub-module, vga_sync_edge, instantiated twice (Hsync, Vsync).

Verification
REQ-023 The bench SHALL cover these scenarios:
- Nominal 800x525 stream, colour = x[7:0]: locked = 1 at the second Vsync rise after reset; pix (0,0) data 0x00; pix (639,479) data 0x7F; 307200 valid pixels per frame.
- Line 100 shortened to 799 clocks while locked: sync_err pulses once; locked = 0; re-lock after two further good frames.
- Hsync removed while locked: sync_err at h_cnt = 800; no pix_valid afterwards.
- Frame of 524 lines during MEASURE: no sync_err; FSM in SEARCH; lock after the next two good frames.
- rst_n pulsed low mid-line: all outputs 0 in the same cycle; frame_start at the next Vsync rise; locked only after a further full frame.
- Pixel-accurate check: the input sample at h_cnt = 144 appears on pix_data exactly 2 clocks later, with pix_x = 0.
